core_seq_ctrl: RTL

- Autonomous sequencer for the systolic core. Replaces the hand-driven instruction word from the testbench.
- On one `start` pulse it runs a whole layer: weight load, activation streaming, drain, and psum accumulate/write-back over `cfg_tiles` kernel tiles.
- Supports Weight-Stationary (WS) and Output-Stationary (OS) modes.
- Sits between the host/testbench and the corelet + xmem + psum SRAMs. Drives all their strobes and addresses.

---
 rtl/core_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: autonomous layer sequencer for the systolic core.
// One start pulse runs weight load, activation streaming, drain and psum
// accumulate/write-back over cfg_tiles tiles, in WS or OS mode.
// All outputs are registered; SRAM strobes are active-low.
// Optional build macro CORE_SEQ_PERF_EN adds perf_cycles / perf_stalls.
module core_seq_ctrl #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 11,
    parameter int TILE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cfg_mode,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_x_base,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mode,
    output logic              xmem_cen,
    output logic              xmem_wen,
    output logic [ADDR_W-1:0] xmem_addr,
    output logic              pmem_cen,
    output logic              pmem_wen,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              l0_wr,
    output logic              load,
    output logic              execute,
    output logic              ofifo_rd,
    output logic              acc
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    typedef enum logic [2:0] {IDLE, WLOAD, WPUSH, ACT, DRAIN, ACC, WB, FIN} state_t;
    typedef enum logic [1:0] {PH_READ, PH_WAIT, PH_WRITE} acc_ph_t;

    localparam logic [LEN_W-1:0] COL_LAST  = LEN_W'(COL - 1);
    localparam logic [LEN_W-1:0] FILL_LAST = LEN_W'(ROW + COL - 1);

    // Sequencer state and latched configuration
    state_t              state_q, state_d;
    acc_ph_t             ph_q, ph_d;
    logic [TILE_W-1:0]   t_q, t_d;
    logic [LEN_W-1:0]    i_q, i_d;
    logic [LEN_W-1:0]    len_q;
    logic [TILE_W-1:0]   tiles_q;
    logic [ADDR_W-1:0]   w_base_q, x_base_q;

    // Delayed-strobe bookkeeping (survives stalls)
    logic                l0_owed_q, l0_owed_d;
    logic                wb_tag_q, wb_tag_d;
    logic [ADDR_W-1:0]   wb_tag_addr_q, wb_tag_addr_d;
    logic                wb_owed_q, wb_owed_d;
    logic [ADDR_W-1:0]   wb_owed_addr_q;

    // Next-cycle output values
    logic                accept, err_d, done_d;
    logic                x_rd_d;
    logic [ADDR_W-1:0]   x_addr_d, w_addr, x_addr;
    logic                p_cen_d, p_wen_d;
    logic [ADDR_W-1:0]   p_addr_d;
    logic                load_d, exec_d, ofifo_d, acc_d, l0_d;
    logic                t_last, stall_hold, l0_pend, wb_pend;
    logic [ADDR_W-1:0]   wb_pend_addr;

    // Next-state, counter and output decode for the current position
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d       = state_q;
        ph_d          = ph_q;
        t_d           = t_q;
        i_d           = i_q;
        accept        = 1'b0;
        err_d         = 1'b0;
        done_d        = 1'b0;
        x_rd_d        = 1'b0;
        x_addr_d      = xmem_addr;
        p_cen_d       = 1'b1;
        p_wen_d       = 1'b1;
        p_addr_d      = pmem_addr;
        load_d        = 1'b0;
        exec_d        = 1'b0;
        ofifo_d       = 1'b0;
        acc_d         = 1'b0;
        wb_tag_d      = 1'b0;
        wb_tag_addr_d = wb_tag_addr_q;

        t_last = (t_q == tiles_q - TILE_W'(1));
        w_addr = w_base_q + ADDR_W'(t_q * COL) + ADDR_W'(i_q);
        // OS re-streams the same activation block for every tile
        x_addr = x_base_q + (mode ? '0 : ADDR_W'(32'(t_q) * ROW * 32'(len_q))) + ADDR_W'(i_q);

        if (state_q == IDLE) begin
            if (start) begin
                if (cfg_len != '0 && cfg_tiles != '0) begin
                    accept  = 1'b1;
                    state_d = cfg_mode ? ACT : WLOAD;
                    t_d     = '0;
                    i_d     = '0;
                    ph_d    = PH_READ;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (!stall) begin
            case (state_q)
                WLOAD: begin
                    x_rd_d   = 1'b1;
                    x_addr_d = w_addr;
                    if (i_q == COL_LAST) begin
                        i_d     = '0;
                        state_d = WPUSH;
                    end else begin
                        i_d = i_q + LEN_W'(1);
                    end
                end
                WPUSH: begin
                    load_d = 1'b1;
                    if (i_q == FILL_LAST) begin
                        i_d     = '0;
                        state_d = ACT;
                    end else begin
                        i_d = i_q + LEN_W'(1);
                    end
                end
                ACT: begin
                    x_rd_d   = 1'b1;
                    x_addr_d = x_addr;
                    exec_d   = 1'b1;
                    if (i_q == len_q - LEN_W'(1)) begin
                        i_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        i_d = i_q + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    exec_d = 1'b1;
                    if (i_q == FILL_LAST) begin
                        i_d = '0;
                        if (!mode) begin
                            state_d = ACC;
                            ph_d    = PH_READ;
                        end else if (!t_last) begin
                            t_d     = t_q + TILE_W'(1);
                            state_d = ACT;
                        end else begin
                            state_d = WB;
                        end
                    end else begin
                        i_d = i_q + LEN_W'(1);
                    end
                end
                ACC: begin
                    p_addr_d = ADDR_W'(i_q);
                    case (ph_q)
                        PH_READ: begin
                            ofifo_d = 1'b1;
                            // first tile overwrites: no psum read, no accumulate
                            if (t_q != '0) begin
                                p_cen_d = 1'b0;
                                acc_d   = 1'b1;
                            end
                            ph_d = PH_WAIT;
                        end
                        PH_WAIT: ph_d = PH_WRITE;
                        PH_WRITE: begin
                            p_cen_d = 1'b0;
                            p_wen_d = 1'b0;
                            acc_d   = (t_q != '0);
                            ph_d    = PH_READ;
                            if (i_q == len_q - LEN_W'(1)) begin
                                i_d = '0;
                                if (!t_last) begin
                                    t_d     = t_q + TILE_W'(1);
                                    state_d = WLOAD;
                                end else begin
                                    state_d = FIN;
                                end
                            end else begin
                                i_d = i_q + LEN_W'(1);
                            end
                        end
                        default: ph_d = PH_READ;
                    endcase
                end
                WB: begin
                    ofifo_d       = 1'b1;
                    wb_tag_d      = 1'b1;
                    wb_tag_addr_d = ADDR_W'(i_q);
                    if (i_q == COL_LAST) begin
                        i_d     = '0;
                        state_d = FIN;
                    end else begin
                        i_d = i_q + LEN_W'(1);
                    end
                end
                FIN: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Strobes that trail a read by one cycle are held across a stall and
        // issued on the first unstalled cycle.
        stall_hold   = stall && (state_q != IDLE);
        l0_pend      = l0_owed_q | ~xmem_cen;
        l0_d         = l0_pend & ~stall_hold;
        l0_owed_d    = l0_pend & stall_hold;
        wb_pend      = wb_owed_q | wb_tag_q;
        wb_pend_addr = wb_tag_q ? wb_tag_addr_q : wb_owed_addr_q;
        wb_owed_d    = wb_pend & stall_hold;
        if (wb_pend && !stall_hold) begin
            p_cen_d  = 1'b0;
            p_wen_d  = 1'b0;
            p_addr_d = wb_pend_addr;
        end
    end

    // State, configuration and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q        <= IDLE;
            ph_q           <= PH_READ;
            t_q            <= '0;
            i_q            <= '0;
            len_q          <= '0;
            tiles_q        <= '0;
            w_base_q       <= '0;
            x_base_q       <= '0;
            l0_owed_q      <= 1'b0;
            wb_tag_q       <= 1'b0;
            wb_tag_addr_q  <= '0;
            wb_owed_q      <= 1'b0;
            wb_owed_addr_q <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            mode           <= 1'b0;
            xmem_cen       <= 1'b1;
            xmem_wen       <= 1'b1;
            xmem_addr      <= '0;
            pmem_cen       <= 1'b1;
            pmem_wen       <= 1'b1;
            pmem_addr      <= '0;
            l0_wr          <= 1'b0;
            load           <= 1'b0;
            execute        <= 1'b0;
            ofifo_rd       <= 1'b0;
            acc            <= 1'b0;
        end else begin
            state_q        <= state_d;
            ph_q           <= ph_d;
            t_q            <= t_d;
            i_q            <= i_d;
            if (accept) begin
                len_q    <= cfg_len;
                tiles_q  <= cfg_tiles;
                w_base_q <= cfg_w_base;
                x_base_q <= cfg_x_base;
                mode     <= cfg_mode;
            end
            l0_owed_q      <= l0_owed_d;
            wb_tag_q       <= wb_tag_d;
            wb_tag_addr_q  <= wb_tag_addr_d;
            wb_owed_q      <= wb_owed_d;
            wb_owed_addr_q <= wb_pend_addr;
            busy           <= (state_d != IDLE);
            done           <= done_d;
            err            <= err_d;
            xmem_cen       <= ~x_rd_d;
            xmem_wen       <= 1'b1;
            xmem_addr      <= x_addr_d;
            pmem_cen       <= p_cen_d;
            pmem_wen       <= p_wen_d;
            pmem_addr      <= p_addr_d;
            l0_wr          <= l0_d;
            load           <= load_d;
            execute        <= exec_d;
            ofifo_rd       <= ofifo_d;
            acc            <= acc_d;
        end
    end

`ifdef CORE_SEQ_PERF_EN
    // Saturating busy/stall counters for the most recent layer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (busy) begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
